// File: rtl/riscv_pkg.sv
// Shared definitions for the data-memory port arbiter.
// Owner encoding and data/byte-enable widths.
package riscv_pkg;

  localparam int DW  = 32;
  localparam int BEW = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with burst lock and a hold bound.
// Grants are combinational; owner/last/hold state advances on clk.
module rr_arb2
  import riscv_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req0_i,
  input  logic req1_i,
  input  logic lock0_i,
  input  logic lock1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);

  owner_e        owner_q, owner_d;
  logic          last_q, last_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [HW-1:0] hold_inc;
  logic          keep0, keep1;
  logic          g0, g1;

  assign hold_inc = (hold_q == HMAX) ? hold_q : hold_q + 1'b1;

  // A locked owner keeps the bus unless the other side has waited
  // through MAX_HOLD consecutive locked grants.
  assign keep0 = (owner_q == OWN_M0) && req0_i && lock0_i &&
                 (!req1_i || (hold_q < HMAX));
  assign keep1 = (owner_q == OWN_M1) && req1_i && lock1_i &&
                 (!req0_i || (hold_q < HMAX));

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (keep0) begin
      g0 = 1'b1;
    end else if (keep1) begin
      g1 = 1'b1;
    end else if (req0_i && req1_i) begin
      g0 = last_q;
      g1 = !last_q;
    end else begin
      g0 = req0_i;
      g1 = req1_i;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    last_d  = last_q;
    hold_d  = '0;
    if (g0) begin
      last_d  = 1'b0;
      hold_d  = (owner_q == OWN_M0) ? hold_inc : HW'(1);
      owner_d = lock0_i ? OWN_M0 : OWN_NONE;
    end else if (g1) begin
      last_d  = 1'b1;
      hold_d  = (owner_q == OWN_M1) ? hold_inc : HW'(1);
      owner_d = lock1_i ? OWN_M1 : OWN_NONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OWN_NONE;
      last_q  <= 1'b1;
      hold_q  <= '0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt0_o = g0;
  assign gnt1_o = g1;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port sync data memory between core (M0) and
// debug loader (M1); also publishes the last committed write.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int AW       = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           m0_req,
  input  logic           m0_we,
  input  logic [AW-1:0]  m0_addr,
  input  logic [DW-1:0]  m0_wdata,
  input  logic [BEW-1:0] m0_be,
  input  logic           m0_lock,
  output logic           m0_gnt,
  output logic           m0_rvalid,
  output logic [DW-1:0]  m0_rdata,
  input  logic           m1_req,
  input  logic           m1_we,
  input  logic [AW-1:0]  m1_addr,
  input  logic [DW-1:0]  m1_wdata,
  input  logic [BEW-1:0] m1_be,
  input  logic           m1_lock,
  output logic           m1_gnt,
  output logic           m1_rvalid,
  output logic [DW-1:0]  m1_rdata,
  output logic           mem_en,
  output logic           mem_we,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  output logic [BEW-1:0] mem_be,
  input  logic [DW-1:0]  mem_rdata,
  output logic [31:0]    wr_addr,
  output logic [31:0]    wr_data
);

  logic          rd_pend_q, rd_src_q;
  logic [DW-1:0] m0_rdata_q, m1_rdata_q;
  logic [31:0]   wr_addr_q, wr_data_q;

  rr_arb2 #(
    .MAX_HOLD(MAX_HOLD)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req0_i (m0_req),
    .req1_i (m1_req),
    .lock0_i(m0_lock),
    .lock1_i(m1_lock),
    .gnt0_o (m0_gnt),
    .gnt1_o (m1_gnt)
  );

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (m0_gnt) begin
      mem_en    = 1'b1;
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
      mem_be    = m0_be;
    end else if (m1_gnt) begin
      mem_en    = 1'b1;
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
      mem_be    = m1_be;
    end
  end

  // Valid is registered; data passes straight through from the memory
  // in the return cycle and is latched there to hold until the next one.
  assign m0_rvalid = rd_pend_q && !rd_src_q;
  assign m1_rvalid = rd_pend_q && rd_src_q;
  assign m0_rdata  = m0_rvalid ? mem_rdata : m0_rdata_q;
  assign m1_rdata  = m1_rvalid ? mem_rdata : m1_rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_q  <= 1'b0;
      rd_src_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      rd_pend_q <= mem_en && !mem_we;
      rd_src_q  <= m1_gnt;
      if (m0_rvalid) m0_rdata_q <= mem_rdata;
      if (m1_rvalid) m1_rdata_q <= mem_rdata;
      if (mem_en && mem_we) begin
        wr_addr_q <= 32'(mem_addr);
        wr_data_q <= mem_wdata;
      end
    end
  end

  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter with a behavioural
// arbitration/memory model and a decoupled read-return monitor.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int MH = 4;

  logic        clk = 0;
  logic        rst = 1;
  logic        req[2], we[2], lock[2];
  logic [31:0] addr[2], wdata[2];
  logic [3:0]  be[2];
  logic        gnt[2], rvalid[2];
  logic [31:0] rdata[2];
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic [31:0] wr_addr, wr_data;

  mem_port_arbiter #(.AW(AW), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst),
    .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]),
    .m0_wdata(wdata[0]), .m0_be(be[0]), .m0_lock(lock[0]),
    .m0_gnt(gnt[0]), .m0_rvalid(rvalid[0]), .m0_rdata(rdata[0]),
    .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]),
    .m1_wdata(wdata[1]), .m1_be(be[1]), .m1_lock(lock[1]),
    .m1_gnt(gnt[1]), .m1_rvalid(rvalid[1]), .m1_rdata(rdata[1]),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Physical memory attached to the DUT: 1-cycle read latency,
  // random garbage on the read bus when nothing was read.
  logic [31:0] mem[256];
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[7:0]];
    else mem_rdata <= $urandom;
  end

  typedef struct {
    int          port;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sbq[$];

  // Reference model state: who holds a lock, who was served last,
  // how many consecutive locked grants the owner has had.
  logic [31:0] ref_mem[256];
  int          own;
  int          last;
  int          hold;
  logic [31:0] exp_wa, exp_wd;
  logic        gprev[2];

  always @(negedge clk) begin
    int  g;
    bit  keep[2];
    if (rst) begin
      own = 0; last = 1; hold = 0;
      exp_wa = 0; exp_wd = 0;
      gprev[0] = 0; gprev[1] = 0;
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
    end else begin
      for (int x = 0; x < 2; x++)
        keep[x] = (own == x + 1) && req[x] && lock[x] &&
                  (!req[1-x] || hold < MH);
      if (keep[0]) g = 0;
      else if (keep[1]) g = 1;
      else if (req[0] && req[1]) g = 1 - last;
      else if (req[0]) g = 0;
      else if (req[1]) g = 1;
      else g = -1;
      chk("m0_gnt", 32'(gnt[0]), 32'(g == 0));
      chk("m1_gnt", 32'(gnt[1]), 32'(g == 1));
      chk("mem_en", 32'(mem_en), 32'(g >= 0));
      chk("mem_we", 32'(mem_we), (g >= 0) ? 32'(we[g]) : 0);
      chk("mem_addr", mem_addr, (g >= 0) ? addr[g] : 0);
      chk("mem_wdata", mem_wdata, (g >= 0) ? wdata[g] : 0);
      chk("mem_be", 32'(mem_be), (g >= 0) ? 32'(be[g]) : 0);
      chk("wr_addr", wr_addr, exp_wa);
      chk("wr_data", wr_data, exp_wd);
      if (g >= 0) begin
        if (we[g]) begin
          for (int b = 0; b < 4; b++)
            if (be[g][b]) ref_mem[addr[g][7:0]][8*b +: 8] = wdata[g][8*b +: 8];
          exp_wa = addr[g];
          exp_wd = wdata[g];
        end else begin
          sbq.push_back('{port: g, data: ref_mem[addr[g][7:0]], due: cyc + 1});
        end
        hold = (own == g + 1) ? ((hold + 1 > MH) ? MH : hold + 1) : 1;
        own  = lock[g] ? g + 1 : 0;
        last = g;
      end else begin
        own = 0;
        hold = 0;
      end
      gprev[0] = gnt[0];
      gprev[1] = gnt[1];
    end
  end

  // Read-return monitor.
  logic [31:0] held[2];
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sbq.delete();
      held[0] = 0; held[1] = 0;
      chk("rst_m0_rvalid", 32'(rvalid[0]), 0);
      chk("rst_m1_rvalid", 32'(rvalid[1]), 0);
      chk("rst_m0_rdata", rdata[0], 0);
      chk("rst_m1_rdata", rdata[1], 0);
    end else begin
      if (rvalid[0] && rvalid[1]) chk("rvalid_both", 1, 0);
      if (rvalid[0] || rvalid[1]) begin
        if (sbq.size() == 0) begin
          chk("rvalid_spurious", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("rv_port", 32'(rvalid[1]), 32'(e.port));
          chk("rv_cycle", 32'(cyc), 32'(e.due));
          chk("rv_data", rdata[e.port], e.data);
          held[e.port] = e.data;
        end
      end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        chk("rv_missing", 0, 1);
      end
      if (!rvalid[0]) chk("m0_rdata_hold", rdata[0], held[0]);
      if (!rvalid[1]) chk("m1_rdata_hold", rdata[1], held[1]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(int x, logic r, logic w, logic [31:0] a,
                     logic [31:0] d, logic [3:0] b, logic l);
    req[x] = r; we[x] = w; addr[x] = a;
    wdata[x] = d; be[x] = b; lock[x] = l;
  endtask

  task automatic idle_all();
    drv(0, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[16] = 32'hDEADBEEF;
    ref_mem[16] = 32'hDEADBEEF;
    mem_rdata = 0;
    idle_all();
    repeat (3) step();
    rst = 0;

    // Both masters read continuously, no lock: strict alternation.
    drv(0, 1, 0, 32'h21, 0, 0, 0);
    drv(1, 1, 0, 32'h32, 0, 0, 0);
    repeat (8) step();
    idle_all();
    step();

    // Single M0 read of 0x10.
    drv(0, 1, 0, 32'h10, 0, 0, 0);
    step();
    idle_all();
    repeat (2) step();

    // Idle window.
    repeat (10) step();

    // M0 full-word write, then idle while wr_* must hold.
    drv(0, 1, 1, 32'h40, 32'h12345678, 4'hF, 0);
    step();
    idle_all();
    repeat (3) step();

    // M1 locked burst against a waiting M0.
    drv(0, 1, 0, 32'h05, 0, 0, 0);
    drv(1, 1, 0, 32'h06, 0, 0, 1);
    repeat (8) step();
    idle_all();
    step();

    // M1 read, then reset before the return cycle completes.
    drv(1, 1, 0, 32'h10, 0, 0, 0);
    step();
    idle_all();
    rst = 1;
    repeat (2) step();
    rst = 0;
    drv(0, 1, 0, 32'h11, 0, 0, 0);
    drv(1, 1, 0, 32'h12, 0, 0, 0);
    repeat (2) step();
    idle_all();
    step();

    // Random traffic; a waiting master keeps its fields stable.
    for (int n = 0; n < 3000; n++) begin
      for (int x = 0; x < 2; x++) begin
        if (!(req[x] && !gprev[x])) begin
          drv(x, ($urandom % 3) != 0, ($urandom % 3) == 0,
              32'($urandom % 256), $urandom, 4'($urandom),
              ($urandom % 2) == 0);
        end
      end
      step();
    end
    idle_all();
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
